// File: rtl/pipelined_alu_stream_if.sv
// Stream bundle for the pipelined ALU: issue-side request, writeback-side result and flags.
interface pipelined_alu_stream_if #(
   parameter int WIDTH = 16,
   parameter int TAG_W = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [3:0]       op;
   logic [TAG_W-1:0] tag;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic [TAG_W-1:0] out_tag;
   logic             overflow;
   logic             underflow;
   logic             invalid_op;
   logic             is_equal;
   logic             is_less;
   logic             is_less_s;
   logic [7:0]       err_cnt;

   modport master (
      output in_valid, a, b, op, tag, out_ready,
      input  in_ready, out_valid, result, out_tag, overflow, underflow,
             invalid_op, is_equal, is_less, is_less_s, err_cnt
   );

   modport slave (
      input  in_valid, a, b, op, tag, out_ready,
      output in_ready, out_valid, result, out_tag, overflow, underflow,
             invalid_op, is_equal, is_less, is_less_s, err_cnt
   );
endinterface

// File: rtl/pipelined_alu_stream.sv
// Two-stage valid/ready ALU: S1 captures the request, S2 computes and holds result and flags.
module pipelined_alu_stream #(
   parameter int WIDTH = 16,
   parameter int TAG_W = 4
) (
   input logic                    clk,
   input logic                    rst,
   pipelined_alu_stream_if.slave  bus
);
   localparam int SH_W = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

   // Clamp a WIDTH+1 signed sum to WIDTH bits; returns {overflow, underflow, value}.
   function automatic logic [WIDTH+1:0] saturate(input logic signed [WIDTH:0] s);
      if (s[WIDTH] == s[WIDTH-1]) return {2'b00, s[WIDTH-1:0]};
      else if (!s[WIDTH])         return {2'b10, SMAX};
      else                        return {2'b01, SMIN};
   endfunction

   logic                    vld_p1;
   logic [WIDTH-1:0]        a_p1;
   logic [WIDTH-1:0]        b_p1;
   logic [3:0]              op_p1;
   logic [TAG_W-1:0]        tag_p1;

   logic                    vld_p2;
   logic [WIDTH-1:0]        result_p2;
   logic [TAG_W-1:0]        tag_p2;
   logic                    ov_p2, uf_p2, inv_p2, eq_p2, lt_p2, lts_p2;
   logic [7:0]              err_cnt;

   logic                    s2_adv;
   logic                    accept;

   assign s2_adv       = !vld_p2 || bus.out_ready;
   assign bus.in_ready = !vld_p1 || s2_adv;
   assign accept       = bus.in_valid && bus.in_ready;

   // ---- Stage 1: request capture ----
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)          vld_p1 <= 1'b0;
      else if (accept)   vld_p1 <= 1'b1;
      else if (s2_adv)   vld_p1 <= 1'b0;
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         a_p1   <= bus.a;
         b_p1   <= bus.b;
         op_p1  <= bus.op;
         tag_p1 <= bus.tag;
      end
   end

   logic signed [WIDTH-1:0] sa, sb;
   logic [WIDTH:0]          usum, udiff;
   logic signed [WIDTH:0]   ssum, sdiff;
   logic [SH_W-1:0]         shamt;
   logic [WIDTH-1:0]        res_c;
   logic                    ov_c, uf_c, inv_c;

   assign sa    = a_p1;
   assign sb    = b_p1;
   assign usum  = {1'b0, a_p1} + {1'b0, b_p1};
   assign udiff = {1'b0, a_p1} - {1'b0, b_p1};
   assign ssum  = $signed({sa[WIDTH-1], sa}) + $signed({sb[WIDTH-1], sb});
   assign sdiff = $signed({sa[WIDTH-1], sa}) - $signed({sb[WIDTH-1], sb});
   assign shamt = b_p1[SH_W-1:0];

   always_comb begin
      res_c = '0;
      ov_c  = 1'b0;
      uf_c  = 1'b0;
      inv_c = 1'b0;
      case (op_p1)
         4'h0: begin res_c = usum[WIDTH-1:0];  ov_c = usum[WIDTH];  end
         4'h1: begin res_c = udiff[WIDTH-1:0]; uf_c = udiff[WIDTH]; end
         4'h2: res_c = a_p1 & b_p1;
         4'h3: res_c = a_p1 | b_p1;
         4'h4: res_c = a_p1 ^ b_p1;
         4'h5: res_c = ~a_p1;
         4'h6: res_c = a_p1 << shamt;
         4'h7: res_c = a_p1 >> shamt;
         4'h8: res_c = sa >>> shamt;
         4'h9: res_c = '0;
         4'hA: {ov_c, uf_c, res_c} = saturate(ssum);
         4'hB: {ov_c, uf_c, res_c} = saturate(sdiff);
         4'hC: res_c = (a_p1 < b_p1) ? a_p1 : b_p1;
         4'hD: res_c = (a_p1 < b_p1) ? b_p1 : a_p1;
         default: inv_c = 1'b1;
      endcase
   end

   // ---- Stage 2: result register, held while the consumer stalls ----
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_p2    <= 1'b0;
         result_p2 <= '0;
         tag_p2    <= '0;
         ov_p2     <= 1'b0;
         uf_p2     <= 1'b0;
         inv_p2    <= 1'b0;
         eq_p2     <= 1'b0;
         lt_p2     <= 1'b0;
         lts_p2    <= 1'b0;
         err_cnt   <= 8'd0;
      end else begin
         if (s2_adv) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
               result_p2 <= res_c;
               tag_p2    <= tag_p1;
               ov_p2     <= ov_c;
               uf_p2     <= uf_c;
               inv_p2    <= inv_c;
               eq_p2     <= (a_p1 == b_p1);
               lt_p2     <= (a_p1 < b_p1);
               lts_p2    <= (sa < sb);
            end
         end
         if (vld_p2 && bus.out_ready && inv_p2 && (err_cnt != 8'hFF))
            err_cnt <= err_cnt + 8'd1;
      end
   end

   assign bus.out_valid  = vld_p2;
   assign bus.result     = result_p2;
   assign bus.out_tag    = tag_p2;
   assign bus.overflow   = ov_p2;
   assign bus.underflow  = uf_p2;
   assign bus.invalid_op = inv_p2;
   assign bus.is_equal   = eq_p2;
   assign bus.is_less    = lt_p2;
   assign bus.is_less_s  = lts_p2;
   assign bus.err_cnt    = err_cnt;
endmodule
